// File: rtl/uart_core_param.sv
// Full-duplex UART with TX/RX byte FIFOs, configurable frame format, runtime baud divisor
// and sticky parity/framing/overrun flags. Rx is asynchronous and passes a 2-flop synchroniser.

module uart_core_param_fifo #(
  parameter int AW = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_push,
  input  logic [7:0] i_dat,
  input  logic       i_pop,
  output logic [7:0] o_dat,
  output logic       o_full,
  output logic       o_empty
);
  logic [7:0]  r_mem [2**AW];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic        w_wr;
  logic        w_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_dat   = o_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_dat;
  end
endmodule

module uart_core_param #(
  parameter int CLOCKRATE = 40000000,
  parameter int BAUDRATE  = 2304000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        send_flag,
  input  logic [7:0]  send_data,
  output logic        sendable,
  input  logic        recv_flag,
  output logic [7:0]  recv_data,
  output logic        receivable,
  input  logic [15:0] div_cfg,
  input  logic        err_clear,
  output logic        err_parity,
  output logic        err_frame,
  output logic        err_overrun,
  output logic        tx_busy,
  output logic        Tx,
  input  logic        Rx
);
  localparam logic [15:0] DIV_DEF  = 16'(CLOCKRATE / BAUDRATE);
  localparam logic [7:0]  DMASK    = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic        PAR_ODD  = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

  logic [15:0] w_div;
  always_comb begin
    w_div = (div_cfg == 16'd0) ? DIV_DEF : div_cfg;
    if (w_div < 16'd4) w_div = 16'd4;
  end

  state_t      r_tx_state;
  logic [15:0] r_tx_div;
  logic [16:0] r_tx_cnt;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_idx;
  logic        r_tx_par;
  logic        r_tx;
  logic        w_txf_empty;
  logic        w_txf_full;
  logic [7:0]  w_txf_dat;
  logic [7:0]  w_tx_byte;
  logic [16:0] w_tx_len;
  logic        w_tx_end;
  logic        w_tx_pop;

  assign w_tx_byte = w_txf_dat & DMASK;
  assign w_tx_len  = (r_tx_state == S_STOP && STOP_BITS == 2) ? {r_tx_div, 1'b0} : {1'b0, r_tx_div};
  assign w_tx_end  = (r_tx_cnt == w_tx_len - 17'd1);
  // Popping at the end of STOP chains frames with no idle gap.
  assign w_tx_pop  = !w_txf_empty && (r_tx_state == S_IDLE || (r_tx_state == S_STOP && w_tx_end));

  uart_core_param_fifo #(.AW(FIFO_AW)) u_txf (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (send_flag),
    .i_dat   (send_data),
    .i_pop   (w_tx_pop),
    .o_dat   (w_txf_dat),
    .o_full  (w_txf_full),
    .o_empty (w_txf_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx_state <= S_IDLE;
      r_tx_div   <= DIV_DEF;
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else if (w_tx_pop) begin
      r_tx_state <= S_START;
      r_tx_div   <= w_div;
      r_tx_cnt   <= '0;
      r_tx_shift <= w_tx_byte;
      r_tx_par   <= (^w_tx_byte) ^ PAR_ODD;
      r_tx       <= 1'b0;
    end else if (r_tx_state != S_IDLE) begin
      if (!w_tx_end) begin
        r_tx_cnt <= r_tx_cnt + 17'd1;
      end else begin
        r_tx_cnt <= '0;
        case (r_tx_state)
          S_START: begin
            r_tx_state <= S_DATA;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_idx   <= '0;
          end
          S_DATA: begin
            if (r_tx_idx == LAST_BIT) begin
              if (PARITY != 0) begin
                r_tx_state <= S_PARITY;
                r_tx       <= r_tx_par;
              end else begin
                r_tx_state <= S_STOP;
                r_tx       <= 1'b1;
              end
            end else begin
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end
          S_PARITY: begin
            r_tx_state <= S_STOP;
            r_tx       <= 1'b1;
          end
          default: begin
            r_tx_state <= S_IDLE;
            r_tx       <= 1'b1;
          end
        endcase
      end
    end
  end

  assign Tx       = r_tx;
  assign sendable = !w_txf_full;
  assign tx_busy  = (r_tx_state != S_IDLE) || !w_txf_empty;

  logic        r_rx_s1;
  logic        r_rx_s2;
  state_t      r_rx_state;
  logic [15:0] r_rx_div;
  logic [15:0] r_rx_cnt;
  logic [7:0]  r_rx_shift;
  logic [2:0]  r_rx_idx;
  logic        r_rx_stop_idx;
  logic        r_rx_perr;
  logic        r_rx_wr;
  logic [7:0]  r_rx_wdat;
  logic        r_err_parity;
  logic        r_err_frame;
  logic        r_err_overrun;
  logic        w_rx;
  logic        w_rx_hit;
  logic [15:0] w_rx_tgt;
  logic [7:0]  w_rx_byte;
  logic        w_rxf_full;
  logic        w_rxf_empty;
  logic        w_par_evt;
  logic        w_frame_evt;
  logic        w_ovr_evt;

  assign w_rx      = r_rx_s2;
  assign w_rx_byte = r_rx_shift >> (8 - DATA_BITS);
  assign w_rx_tgt  = (r_rx_state == S_START) ? {1'b0, r_rx_div[15:1]} : r_rx_div;
  assign w_rx_hit  = (r_rx_cnt == w_rx_tgt - 16'd1);

  assign w_par_evt   = (r_rx_state == S_PARITY) && w_rx_hit && (w_rx != ((^w_rx_byte) ^ PAR_ODD));
  assign w_frame_evt = (r_rx_state == S_STOP) && w_rx_hit && !w_rx;
  assign w_ovr_evt   = r_rx_wr && w_rxf_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_s1       <= 1'b1;
      r_rx_s2       <= 1'b1;
      r_rx_state    <= S_IDLE;
      r_rx_div      <= DIV_DEF;
      r_rx_cnt      <= '0;
      r_rx_shift    <= '0;
      r_rx_idx      <= '0;
      r_rx_stop_idx <= 1'b0;
      r_rx_perr     <= 1'b0;
      r_rx_wr       <= 1'b0;
      r_rx_wdat     <= '0;
    end else begin
      r_rx_s1 <= Rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_wr <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_rx_state <= S_START;
            r_rx_div   <= w_div;
            r_rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (w_rx_hit) begin
            r_rx_cnt <= '0;
            if (w_rx) begin
              r_rx_state <= S_IDLE;
            end else begin
              r_rx_state <= S_DATA;
              r_rx_idx   <= '0;
              r_rx_perr  <= 1'b0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_rx_hit) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
            if (r_rx_idx == LAST_BIT) begin
              r_rx_stop_idx <= 1'b0;
              if (PARITY != 0) r_rx_state <= S_PARITY;
              else r_rx_state <= S_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (w_rx_hit) begin
            r_rx_cnt      <= '0;
            r_rx_perr     <= w_par_evt;
            r_rx_stop_idx <= 1'b0;
            r_rx_state    <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_rx_hit) begin
            r_rx_cnt <= '0;
            if (!w_rx) begin
              r_rx_state <= S_WAIT;
            end else if (r_rx_stop_idx || STOP_BITS == 1) begin
              r_rx_state <= S_IDLE;
              r_rx_wr    <= !r_rx_perr;
              r_rx_wdat  <= w_rx_byte;
            end else begin
              r_rx_stop_idx <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_WAIT: begin
          if (w_rx) r_rx_state <= S_IDLE;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  uart_core_param_fifo #(.AW(FIFO_AW)) u_rxf (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (r_rx_wr),
    .i_dat   (r_rx_wdat),
    .i_pop   (recv_flag),
    .o_dat   (recv_data),
    .o_full  (w_rxf_full),
    .o_empty (w_rxf_empty)
  );

  assign receivable = !w_rxf_empty;

  // A new error event outranks a clear in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err_parity  <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_parity  <= w_par_evt   || (r_err_parity  && !err_clear);
      r_err_frame   <= w_frame_evt || (r_err_frame   && !err_clear);
      r_err_overrun <= w_ovr_evt   || (r_err_overrun && !err_clear);
    end
  end

  assign err_parity  = r_err_parity;
  assign err_frame   = r_err_frame;
  assign err_overrun = r_err_overrun;
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: 8E1 loopback/directed-Rx instance, a 7N2 instance and a
// 4-deep-FIFO loopback instance, checked against bench-side scoreboards.

module tb_uart_core_param;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int tx_frames = 0;
  bit mon_en = 1'b1;

  logic [15:0] div_cfg = 16'd16;
  logic        err_clear = 1'b0;

  logic       send_flag_a = 1'b0;
  logic [7:0] send_data_a = 8'h00;
  logic       recv_flag_a = 1'b0;
  logic       loop_a = 1'b0;
  logic       rx_a_drv = 1'b1;
  logic       sendable_a, receivable_a, err_parity_a, err_frame_a, err_overrun_a, tx_busy_a, Tx_a, Rx_a;
  logic [7:0] recv_data_a;
  assign Rx_a = loop_a ? Tx_a : rx_a_drv;

  logic       send_flag_b = 1'b0;
  logic [7:0] send_data_b = 8'h00;
  logic       recv_flag_b = 1'b0;
  logic       rx_b_drv = 1'b1;
  logic       sendable_b, receivable_b, err_parity_b, err_frame_b, err_overrun_b, tx_busy_b, Tx_b;
  logic [7:0] recv_data_b;

  logic       send_flag_c = 1'b0;
  logic [7:0] send_data_c = 8'h00;
  logic       recv_flag_c = 1'b0;
  logic       sendable_c, receivable_c, err_parity_c, err_frame_c, err_overrun_c, tx_busy_c, Tx_c;
  logic [7:0] recv_data_c;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp_a[$];
  logic [7:0] rx_exp_b[$];
  logic [7:0] rx_exp_c[$];

  uart_core_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(4)) dut_a (
    .CLK(CLK), .RST(RST), .send_flag(send_flag_a), .send_data(send_data_a), .sendable(sendable_a),
    .recv_flag(recv_flag_a), .recv_data(recv_data_a), .receivable(receivable_a), .div_cfg(div_cfg),
    .err_clear(err_clear), .err_parity(err_parity_a), .err_frame(err_frame_a),
    .err_overrun(err_overrun_a), .tx_busy(tx_busy_a), .Tx(Tx_a), .Rx(Rx_a)
  );

  uart_core_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_AW(4)) dut_b (
    .CLK(CLK), .RST(RST), .send_flag(send_flag_b), .send_data(send_data_b), .sendable(sendable_b),
    .recv_flag(recv_flag_b), .recv_data(recv_data_b), .receivable(receivable_b), .div_cfg(div_cfg),
    .err_clear(err_clear), .err_parity(err_parity_b), .err_frame(err_frame_b),
    .err_overrun(err_overrun_b), .tx_busy(tx_busy_b), .Tx(Tx_b), .Rx(rx_b_drv)
  );

  uart_core_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(2)) dut_c (
    .CLK(CLK), .RST(RST), .send_flag(send_flag_c), .send_data(send_data_c), .sendable(sendable_c),
    .recv_flag(recv_flag_c), .recv_data(recv_data_c), .receivable(receivable_c), .div_cfg(div_cfg),
    .err_clear(err_clear), .err_parity(err_parity_c), .err_frame(err_frame_c),
    .err_overrun(err_overrun_c), .tx_busy(tx_busy_c), .Tx(Tx_c), .Rx(Tx_c)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic vld_of(input int w);
    case (w)
      0:       return receivable_a;
      1:       return receivable_b;
      default: return receivable_c;
    endcase
  endfunction

  function automatic logic [7:0] dat_of(input int w);
    case (w)
      0:       return recv_data_a;
      1:       return recv_data_b;
      default: return recv_data_c;
    endcase
  endfunction

  task automatic pop_rx(input int w);
    case (w)
      0:       recv_flag_a = 1'b1;
      1:       recv_flag_b = 1'b1;
      default: recv_flag_c = 1'b1;
    endcase
    tick();
    recv_flag_a = 1'b0;
    recv_flag_b = 1'b0;
    recv_flag_c = 1'b0;
  endtask

  // Wait (bounded) for a received byte, compare with the scoreboard head, then pop it.
  task automatic expect_rx(input int w, input string tag);
    logic [7:0] e;
    e = 8'hEE;
    for (int i = 0; i < 400 && !vld_of(w); i++) tick();
    chk({tag, "_vld"}, 32'(vld_of(w)), 32'd1);
    case (w)
      0:       if (rx_exp_a.size() > 0) e = rx_exp_a.pop_front();
      1:       if (rx_exp_b.size() > 0) e = rx_exp_b.pop_front();
      default: if (rx_exp_c.size() > 0) e = rx_exp_c.pop_front();
    endcase
    chk({tag, "_dat"}, 32'(dat_of(w)), 32'(e));
    pop_rx(w);
  endtask

  task automatic drive_rx(input bit to_b, input logic [11:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      if (to_b) rx_b_drv = bits[k];
      else rx_a_drv = bits[k];
      tick(16);
    end
    if (to_b) rx_b_drv = 1'b1;
    else rx_a_drv = 1'b1;
  endtask

  // Tx_a frame decoder: samples mid-bit and checks against the TX scoreboard.
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    logic       p;
    logic       s;
    forever begin
      @(negedge Tx_a);
      tick(8);
      for (int i = 0; i < 8; i++) begin
        tick(16);
        d[i] = Tx_a;
      end
      tick(16);
      p = Tx_a;
      tick(16);
      s = Tx_a;
      if (mon_en) begin
        tx_frames++;
        e = 8'hEE;
        if (tx_exp.size() > 0) e = tx_exp.pop_front();
        chk("tx_frame_dat", 32'(d), 32'(e));
        chk("tx_frame_par", 32'(p), 32'(^e));
        chk("tx_frame_stop", 32'(s), 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b;
    logic [10:0] fb;

    #1 RST = 1'b1;
    tick(3);
    chk("rst_tx", 32'(Tx_a), 32'd1);
    chk("rst_sendable", 32'(sendable_a), 32'd1);
    chk("rst_receivable", 32'(receivable_a), 32'd0);
    chk("rst_recv_data", 32'(recv_data_a), 32'd0);
    chk("rst_tx_busy", 32'(tx_busy_a), 32'd0);
    chk("rst_errs", 32'({err_parity_a, err_frame_a, err_overrun_a}), 32'd0);
    RST = 1'b0;
    tick(3);

    // 8E1 loopback of 0xA5 with exact bit timing.
    loop_a = 1'b1;
    b = 8'hA5;
    fb = {1'b1, ^b, b, 1'b0};
    send_flag_a = 1'b1;
    send_data_a = b;
    tx_exp.push_back(b);
    rx_exp_a.push_back(b);
    tick();
    send_flag_a = 1'b0;
    chk("t1_tx_before_fall", 32'(Tx_a), 32'd1);
    chk("t1_busy", 32'(tx_busy_a), 32'd1);
    for (int k = 0; k < 11; k++) begin
      tick(1);
      chk($sformatf("t1_bit%0d_first", k), 32'(Tx_a), 32'(fb[k]));
      tick(15);
      chk($sformatf("t1_bit%0d_last", k), 32'(Tx_a), 32'(fb[k]));
    end
    expect_rx(0, "t1_rx");
    chk("t1_empty_after_pop", 32'(receivable_a), 32'd0);
    chk("t1_data_zero_when_empty", 32'(recv_data_a), 32'd0);
    chk("t1_no_err", 32'({err_parity_a, err_frame_a, err_overrun_a}), 32'd0);
    tick(20);
    chk("t1_idle", 32'(tx_busy_a), 32'd0);

    // Bad parity on 0x3C.
    loop_a = 1'b0;
    drive_rx(1'b0, {1'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    tick(20);
    chk("t2_err_parity", 32'(err_parity_a), 32'd1);
    chk("t2_no_byte", 32'(receivable_a), 32'd0);
    chk("t2_no_frame_err", 32'(err_frame_a), 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t2_cleared", 32'(err_parity_a), 32'd0);

    // 7N2: second stop bit low, then a good frame.
    drive_rx(1'b1, {2'b00, 1'b0, 1'b1, 7'h55, 1'b0}, 10);
    tick(20);
    chk("t3_err_frame", 32'(err_frame_b), 32'd1);
    chk("t3_no_byte", 32'(receivable_b), 32'd0);
    rx_exp_b.push_back(8'h2A);
    drive_rx(1'b1, {2'b00, 1'b1, 1'b1, 7'h2A, 1'b0}, 10);
    expect_rx(1, "t3_rx");
    chk("t3_err_frame_sticky", 32'(err_frame_b), 32'd1);

    // Depth-4 RX FIFO overrun through loopback.
    for (int i = 0; i < 5; i++) begin
      send_flag_c = 1'b1;
      send_data_c = 8'(8'h11 + i);
      if (i < 4) rx_exp_c.push_back(8'(8'h11 + i));
      tick();
    end
    send_flag_c = 1'b0;
    for (int i = 0; i < 3000 && !err_overrun_c; i++) tick();
    chk("t4_overrun", 32'(err_overrun_c), 32'd1);
    for (int i = 0; i < 4; i++) expect_rx(2, $sformatf("t4_pop%0d", i));
    chk("t4_drained", 32'(receivable_c), 32'd0);

    // TX FIFO fill: 20 pushes, 17 accepted.
    tx_frames = 0;
    for (int k = 0; k < 20; k++) begin
      send_flag_a = 1'b1;
      send_data_a = 8'(k);
      if (k <= 16) tx_exp.push_back(8'(k));
      tick();
      chk($sformatf("t5_sendable_after_push%0d", k + 1), 32'(sendable_a), (k + 1 <= 16) ? 32'd1 : 32'd0);
    end
    send_flag_a = 1'b0;
    for (int i = 0; i < 4000 && tx_busy_a; i++) tick();
    chk("t5_tx_done", 32'(tx_busy_a), 32'd0);
    chk("t5_frame_count", 32'(tx_frames), 32'd17);
    chk("t5_scoreboard_empty", 32'(tx_exp.size()), 32'd0);

    // Short Rx glitch, then reset in the middle of a TX frame.
    rx_a_drv = 1'b0;
    tick(5);
    rx_a_drv = 1'b1;
    tick(40);
    chk("t6_glitch_no_byte", 32'(receivable_a), 32'd0);
    chk("t6_glitch_no_err", 32'({err_parity_a, err_frame_a, err_overrun_a}), 32'd0);
    mon_en = 1'b0;
    send_flag_a = 1'b1;
    send_data_a = 8'h5A;
    tick();
    send_flag_a = 1'b0;
    tick(1 + 16 * 4 + 5);
    chk("t6_busy_mid_frame", 32'(tx_busy_a), 32'd1);
    RST = 1'b1;
    #1;
    chk("t6_rst_tx_high", 32'(Tx_a), 32'd1);
    chk("t6_rst_busy", 32'(tx_busy_a), 32'd0);
    chk("t6_rst_sendable", 32'(sendable_a), 32'd1);
    tick(2);
    RST = 1'b0;
    tick(5);
    chk("t6_tx_stays_idle", 32'(Tx_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
